// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: sequential vending-transaction controller.
//   A UART command selects an item, and the controller shows that item's
//   price. It then adds up the inserted coins and issues a vend pulse with
//   change, or it refunds the credit on cancel or on inactivity timeout.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   din[N_ITEM]         one-hot product select switches (level)
//   rx_valid/rx_data    UART received byte strobe + data
//   coin_valid/coin_val coin acceptor strobe + value (100-won units)
//   price_out[32]       7-seg display word (byte3 tens, byte2 units, blank 0x11111111)
//   vend/vend_item      dispense pulse + one-hot item
//   change_valid/change returned amount pulse + value
//   sel_err             select command with a non-one-hot din
//   busy                transaction in progress (PAY or SHOW)
module vend_txn_ctrl #(
  parameter int                  N_ITEM      = 4,
  parameter logic [N_ITEM*8-1:0] PRICE_TABLE = {8'd25, 8'd19, 8'd15, 8'd18},
  parameter logic [7:0]          CMD_SEL     = 8'h40,
  parameter logic [7:0]          CMD_CANCEL  = 8'h43,
  parameter int                  TIMEOUT_CYC = 1000,
  parameter int                  SHOW_CYC    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ITEM-1:0] din,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              coin_valid,
  input  logic [7:0]        coin_val,
  output logic [31:0]       price_out,
  output logic              vend,
  output logic [N_ITEM-1:0] vend_item,
  output logic              change_valid,
  output logic [7:0]        change,
  output logic              sel_err,
  output logic              busy
);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SW = (SHOW_CYC > 2) ? $clog2(SHOW_CYC) : 1;
  localparam logic [31:0] BLANK = 32'h11111111;

  typedef enum logic [1:0] {IDLE, PAY, SHOW} state_t;

  state_t            state;
  logic [7:0]        price;
  logic [7:0]        credit;
  logic [N_ITEM-1:0] item;
  logic [TW-1:0]     timer;
  logic [SW-1:0]     show_cnt;

  logic [N_ITEM-1:0][7:0] price_tbl;
  assign price_tbl = PRICE_TABLE;

  // Price of the selected item; only meaningful when din is one-hot.
  logic [7:0] din_price;
  always_comb begin
    din_price = '0;
    for (int i = 0; i < N_ITEM; i++)
      if (din[i]) din_price = din_price | price_tbl[i];
  end

  logic din_onehot;
  assign din_onehot = (din != '0) && ((din & (din - N_ITEM'(1))) == '0);

  // Credit after this cycle's coin, saturated at the 2-digit display limit.
  logic [8:0] sum;
  logic [7:0] credit_add, credit_eff;
  assign sum        = {1'b0, credit} + {1'b0, coin_val};
  assign credit_add = (sum > 9'd99) ? 8'd99 : sum[7:0];
  assign credit_eff = coin_valid ? credit_add : credit;

  logic is_sel, is_cancel, vend_hit, timeout_hit;
  assign is_sel      = rx_valid && (rx_data == CMD_SEL);
  assign is_cancel   = rx_valid && (rx_data == CMD_CANCEL);
  assign vend_hit    = coin_valid && (credit_add >= price);
  // A coin in the same cycle restarts the inactivity window.
  assign timeout_hit = !coin_valid && (timer == TW'(TIMEOUT_CYC - 1));

  function automatic logic [31:0] disp(input logic [7:0] v);
    logic [7:0] tens, units;
    tens  = v / 8'd10;
    units = v % 8'd10;
    return {tens, units, 16'h0000};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      price        <= '0;
      credit       <= '0;
      item         <= '0;
      timer        <= '0;
      show_cnt     <= '0;
      price_out    <= BLANK;
      vend         <= 1'b0;
      vend_item    <= '0;
      change_valid <= 1'b0;
      change       <= '0;
      sel_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      vend         <= 1'b0;
      change_valid <= 1'b0;
      sel_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_valid) begin
            change_valid <= 1'b1;
            change       <= coin_val;
          end
          if (is_sel) begin
            if (din_onehot) begin
              item      <= din;
              price     <= din_price;
              credit    <= '0;
              timer     <= '0;
              price_out <= disp(din_price);
              busy      <= 1'b1;
              state     <= PAY;
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        PAY: begin
          // The coin is accounted first, so a same-cycle cancel either
          // loses to a vend or refunds the coin along with the credit.
          if (vend_hit) begin
            vend         <= 1'b1;
            vend_item    <= item;
            change_valid <= 1'b1;
            change       <= credit_add - price;
            price_out    <= disp(credit_add - price);
            credit       <= '0;
            show_cnt     <= '0;
            state        <= SHOW;
          end else if (is_cancel || timeout_hit) begin
            change_valid <= 1'b1;
            change       <= credit_eff;
            price_out    <= disp(credit_eff);
            credit       <= '0;
            show_cnt     <= '0;
            state        <= SHOW;
          end else begin
            credit <= credit_eff;
            if (coin_valid) begin
              timer     <= '0;
              price_out <= disp(price - credit_add);
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        SHOW: begin
          if (coin_valid) begin
            change_valid <= 1'b1;
            change       <= coin_val;
          end
          if (show_cnt == SW'(SHOW_CYC - 1)) begin
            price_out <= BLANK;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            show_cnt <= show_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_txn_ctrl.sv
module tb_vend_txn_ctrl;
  localparam int TO = 16;
  localparam int SC = 8;
  localparam logic [31:0] BLANK = 32'h11111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  din;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        coin_valid;
  logic [7:0]  coin_val;
  logic [31:0] price_out;
  logic        vend;
  logic [3:0]  vend_item;
  logic        change_valid;
  logic [7:0]  change;
  logic        sel_err;
  logic        busy;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vend_txn_ctrl #(.TIMEOUT_CYC(TO), .SHOW_CYC(SC)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .rx_data(rx_data),
    .coin_valid(coin_valid), .coin_val(coin_val), .price_out(price_out),
    .vend(vend), .vend_item(vend_item), .change_valid(change_valid),
    .change(change), .sel_err(sel_err), .busy(busy)
  );

  function automatic logic [31:0] disp(input int v);
    return 32'((v / 10) * 32'h0100_0000 + (v % 10) * 32'h0001_0000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int prices [4] = '{18, 15, 19, 25};
  logic [31:0] e_po;
  logic        e_vend, e_cv, e_serr, e_busy;
  logic [3:0]  e_item;
  logic [7:0]  e_chg;
  bit          m_ok = 0;
  bit          m_pay = 0;
  int          m_price, m_credit, m_quiet, m_show = 0;
  logic [3:0]  m_item;

  task automatic close_txn(input int amount);
    e_cv   = 1'b1;
    e_chg  = 8'(amount);
    e_po   = disp(amount);
    m_pay  = 0;
    m_show = SC;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; m_pay = 0; m_show = 0; m_credit = 0;
      e_po = BLANK; e_vend = 0; e_cv = 0; e_serr = 0; e_busy = 0;
      e_item = '0; e_chg = '0;
    end else begin
      int c;
      e_vend = 0; e_cv = 0; e_serr = 0;
      if (m_pay) begin
        c = m_credit + (coin_valid ? int'(coin_val) : 0);
        if (c > 99) c = 99;
        if (coin_valid) m_quiet = 0; else m_quiet++;
        if (coin_valid && c >= m_price) begin
          e_vend = 1; e_item = m_item;
          close_txn(c - m_price);
        end else if ((rx_valid && rx_data == 8'h43) || m_quiet == TO) begin
          close_txn(c);
        end else begin
          m_credit = c;
          if (coin_valid) e_po = disp(m_price - c);
        end
      end else begin
        if (coin_valid) begin e_cv = 1; e_chg = coin_val; end
        if (m_show > 0) begin
          m_show--;
          if (m_show == 0) e_po = BLANK;
        end else if (rx_valid && rx_data == 8'h40) begin
          if ($countones(din) == 1) begin
            m_pay = 1; m_item = din; m_price = prices[$clog2(din)];
            m_credit = 0; m_quiet = 0; e_po = disp(m_price);
          end else begin
            e_serr = 1;
          end
        end
      end
      e_busy = m_pay || (m_show > 0);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("price_out",    price_out,           e_po);
      chk("vend",         32'(vend),           32'(e_vend));
      chk("vend_item",    32'(vend_item),      32'(e_item));
      chk("change_valid", 32'(change_valid),   32'(e_cv));
      chk("change",       32'(change),         32'(e_chg));
      chk("sel_err",      32'(sel_err),        32'(e_serr));
      chk("busy",         32'(busy),           32'(e_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    rx_valid = 1; rx_data = b; @(negedge clk); rx_valid = 0;
  endtask
  task automatic coin(input logic [7:0] v);
    coin_valid = 1; coin_val = v; @(negedge clk); coin_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1; din = '0; rx_valid = 0; rx_data = '0; coin_valid = 0; coin_val = '0;
    idle(2);
    chk("lit reset price_out", price_out, BLANK);
    chk("lit reset busy", 32'(busy), 0);
    chk("lit reset change", 32'(change), 0);
    rst = 0;

    // coke: 10, 5, 5 -> vend with change 2
    din = 4'h1; send(8'h40);
    chk("lit coke price", price_out, 32'h01080000);
    chk("lit coke busy", 32'(busy), 1);
    coin(8'd10); chk("lit coke left 8", price_out, 32'h00080000);
    coin(8'd5);  chk("lit coke left 3", price_out, 32'h00030000);
    coin(8'd5);
    chk("lit coke vend", 32'(vend), 1);
    chk("lit coke item", 32'(vend_item), 32'h1);
    chk("lit coke change", 32'(change), 2);
    chk("lit coke disp", price_out, 32'h00020000);
    idle(1); chk("lit vend pulse", 32'(vend), 0);
    idle(6); chk("lit show hold", price_out, 32'h00020000);
    idle(1); chk("lit blank", price_out, BLANK);
    chk("lit idle busy", 32'(busy), 0);

    // beer exact payment
    din = 4'h8; send(8'h40);
    chk("lit beer price", price_out, 32'h02050000);
    coin(8'd25);
    chk("lit beer vend", 32'(vend), 1);
    chk("lit beer change", 32'(change), 0);
    chk("lit beer disp", price_out, 32'h00000000);
    idle(8);

    // soda cancel
    din = 4'h2; send(8'h40); coin(8'd10); send(8'h43);
    chk("lit cancel change", 32'(change), 10);
    chk("lit cancel novend", 32'(vend), 0);
    idle(8); chk("lit cancel idle", 32'(busy), 0);

    // soju timeout
    din = 4'h4; send(8'h40); coin(8'd5);
    idle(15); chk("lit timeout early", 32'(change_valid), 0);
    idle(1);
    chk("lit timeout cv", 32'(change_valid), 1);
    chk("lit timeout change", 32'(change), 5);
    idle(8);

    // bad select, idle coin reject
    din = 4'h3; send(8'h40);
    chk("lit sel_err", 32'(sel_err), 1);
    chk("lit sel_err disp", price_out, BLANK);
    din = 4'h0; coin(8'd7);
    chk("lit reject change", 32'(change), 7);

    // beer: coin + cancel same cycle
    din = 4'h8; send(8'h40);
    coin_valid = 1; coin_val = 8'd20; rx_valid = 1; rx_data = 8'h43;
    @(negedge clk); coin_valid = 0; rx_valid = 0;
    chk("lit coin+cancel change", 32'(change), 20);
    idle(8);

    // beer overpay, coin during SHOW, then saturation
    send(8'h40); coin(8'd60);
    chk("lit overpay change", 32'(change), 35);
    coin(8'd60); chk("lit show reject", 32'(change), 60);
    idle(8);
    send(8'h40); coin(8'd20); coin(8'd250);
    chk("lit saturate change", 32'(change), 74);
    idle(8);

    // reset mid-PAY
    send(8'h40); coin(8'd10);
    rst = 1; @(negedge clk);
    chk("lit rst price_out", price_out, BLANK);
    chk("lit rst busy", 32'(busy), 0);
    chk("lit rst cv", 32'(change_valid), 0);
    chk("lit rst item", 32'(vend_item), 0);
    rst = 0;
    coin(8'd7); chk("lit post-rst reject", 32'(change), 7);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
